instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Program sequencer that sits directly upstream of the ALU/board-interface stage and replaces the free-running ROM address counter. It holds a loadable program memory of 32-bit instruction words and steps a program counter through it. Each word is presented to the downstream stage through a valid/ready handshake, in either paced run mode or single-step mode. Execution halts on an end-of-program marker or on the last address.

Parameters:
DEPTH, 100, number of instruction words in program memory
AW, 7, program counter / address width (2^AW >= DEPTH)
DW, 32, instruction word width
PACE, 4, idle cycles between instructions in run mode (legal range 1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  program memory write strobe
wr_addr  in  AW  program memory write address (ignored if >= DEPTH)
wr_data  in  DW  program memory write data
start  in  1  begin execution from address 0 (level sampled)
stop  in  1  abort execution, return to IDLE
step  in  1  advance one instruction in step mode
mode  in  1  0 = run (paced), 1 = single-step
instr  out  DW  current instruction word, stable while instr_valid=1
instr_valid  out  1  instr holds an untransferred word
instr_ready  in  1  downstream accepts instr this cycle
pc  out  AW  address of the word being fetched/presented
busy  out  1  high in any state other than IDLE/HALT
done  out  1  set on halt, cleared by start or reset

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=0, instr=0, instr_valid=0, busy=0, done=0. Memory contents are not reset; they power up to 0.
- Memory: synchronous write on wr_en at any time. Synchronous read with 1-cycle latency. A write to the address being presented does not alter the latched instr.
- FSM states: IDLE, FETCH, LOAD, PRESENT, PACE, WAITSTEP, HALT.
- IDLE/HALT:
  - start=1 -> FETCH, pc<=0, done<=0.
  - step is ignored.
- FETCH: memory address = pc; -> LOAD next cycle.
- LOAD: instr<=mem[pc], instr_valid<=1; -> PRESENT.
- Latency: start sampled at edge N -> instr_valid=1 after edge N+2.
- PRESENT:
  - instr and instr_valid are held until an edge where instr_valid&instr_ready=1 (transfer).
  - On transfer, instr_valid<=0, then:
    - Halt marker (instr[7:4]==4'hF, the ALU invalid-command code), or pc==DEPTH-1: -> HALT, done<=1, pc unchanged. The halting word itself is still transferred.
    - Otherwise pc<=pc+1; mode=0 -> PACE with pace counter loaded to PACE-1; mode=1 -> WAITSTEP.
  - mode is sampled only at the transfer edge.
- PACE: the counter decrements each cycle; when it is 0 -> FETCH. Net result: exactly PACE cycles between the transfer edge and FETCH.
- WAITSTEP: step=1 -> FETCH. Holding step high gives at most one fetch per completed transfer.
- stop:
  - From any state except IDLE: -> IDLE, instr_valid<=0, pc retained, done unchanged.
  - Stop has priority over all other transitions.
  - If stop coincides with a transfer, the transfer is counted (pc advances) and the state still goes to IDLE.
- start while busy: ignored. start and stop together in IDLE/HALT: stop wins and the state stays IDLE.
- pc never exceeds DEPTH-1; there is no wrap-around.
- busy=1 in FETCH, LOAD, PRESENT, PACE and WAITSTEP.
- Reset asserted mid-operation: immediate return to reset values. Memory contents are preserved.

Test Plan:
- Reset, load mem[0..2]=32'h00100100 and mem[3]=32'h001001F0, mode=0, PACE=4, instr_ready=1, start pulse -> four transfers in order; consecutive instr_valid rising edges 7 cycles apart; after the 4th transfer done=1, busy=0, pc=3.
- Same program, instr_ready=0 for 10 cycles after first valid -> instr=32'h00100100 and instr_valid=1 held constant; pc=0; transfer on the first ready cycle.
- mode=1, start, step pulses at arbitrary gaps -> exactly one new instr_valid per step after each transfer; step held high for 20 cycles still yields one fetch per transfer.
- Program with no halt marker, DEPTH=100 -> halts after transferring address 99; done=1, pc=99, no read at address 0 follows.
- stop asserted in PACE at pc=5 -> IDLE, instr_valid=0, pc=5, busy=0. Then start -> first presented word is mem[0].
- rst_n pulsed low during PRESENT -> instr_valid drops asynchronously, pc=0, done=0. A write issued before reset (mem[7]=32'hDEADBEEF) is still readable after restart.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//
// Bundles every non-clock signal of the instruction sequencer: the program
// memory write port, the execution controls, the instruction valid/ready
// handshake towards the ALU/board stage and the status outputs.
//
// Signals:
//   wr_en, wr_addr, wr_data   program memory write port (host -> sequencer)
//   start, stop, step, mode   execution controls        (host -> sequencer)
//   instr, instr_valid        presented instruction     (sequencer -> stage)
//   instr_ready               downstream accept         (stage -> sequencer)
//   pc, busy, done            status                    (sequencer -> host)
//
// Modports:
//   master   the side that loads the program and consumes instructions
//   slave    the sequencer itself
// ---------------------------------------------------------------------------
interface instr_sequencer_if #(
  parameter int AW = 7,
  parameter int DW = 32
);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          stop;
  logic          step;
  logic          mode;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, step, mode, instr_ready,
    input  instr, instr_valid, pc, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, step, mode, instr_ready,
    output instr, instr_valid, pc, busy, done
  );

endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Program sequencer feeding the ALU/board-interface stage. Holds a loadable
// program memory and walks a program counter through it, presenting each
// word over a valid/ready handshake. In run mode a fixed number of idle
// cycles separates instructions; in single-step mode each further
// instruction waits for a step request. Execution halts on a word whose
// bits [7:4] carry the ALU invalid-command code 4'hF, or after the word at
// the last address.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (memory contents are kept)
//   bus     instr_sequencer_if.slave, carrying:
//             wr_en/wr_addr/wr_data  synchronous memory write
//             start/stop/step/mode   execution control
//             instr/instr_valid/instr_ready  instruction handshake
//             pc/busy/done           status
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int DEPTH = 100,
  parameter int AW    = 7,
  parameter int DW    = 32,
  parameter int PACE  = 4
) (
  input logic                clk,
  input logic                rst_n,
  instr_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PRESENT,
    S_PACE,
    S_WAITSTEP,
    S_HALT
  } state_t;

  localparam logic [AW-1:0] LastAddr  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DepthAddr = AW'(DEPTH);
  localparam logic [7:0]    PaceLoad  = 8'(PACE - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdData_q;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [DW-1:0] instr_q;
  logic          instrValid_q;
  logic          done_q;
  logic [7:0]    paceCnt_q;

  logic          xferNow;
  logic          haltHit;

  // A transfer happens on any edge where the presented word is valid and
  // the downstream stage is ready. The halt decision looks at the word
  // being transferred and at the address it came from.
  assign xferNow = (state_q == S_PRESENT) && instrValid_q && bus.instr_ready;
  assign haltHit = (instr_q[7:4] == 4'hF) || (pc_q == LastAddr);
  assign pc_d    = pc_q + 1'b1;

  // Program memory: writes are accepted at any time, out-of-range addresses
  // are dropped. The read port always follows pc, so the word for the
  // current pc is available one cycle after FETCH. The presented word lives
  // in its own register, so later writes cannot disturb it.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (bus.wr_addr < DepthAddr)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    rdData_q <= mem[pc_q];
  end

  // Sequencing FSM. Stop outranks every other transition; a transfer that
  // coincides with stop still advances pc unless that word was the halting
  // one, so pc never runs past the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      instrValid_q <= 1'b0;
      done_q       <= 1'b0;
      paceCnt_q    <= '0;
    end else if (bus.stop && (state_q != S_IDLE)) begin
      state_q      <= S_IDLE;
      instrValid_q <= 1'b0;
      if (xferNow && !haltHit) begin
        pc_q <= pc_d;
      end
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (bus.start && !bus.stop) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            done_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          instr_q      <= rdData_q;
          instrValid_q <= 1'b1;
          state_q      <= S_PRESENT;
        end
        S_PRESENT: begin
          if (xferNow) begin
            instrValid_q <= 1'b0;
            if (haltHit) begin
              state_q <= S_HALT;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_d;
              if (bus.mode) begin
                state_q <= S_WAITSTEP;
              end else begin
                state_q   <= S_PACE;
                paceCnt_q <= PaceLoad;
              end
            end
          end
        end
        S_PACE: begin
          if (paceCnt_q == 8'd0) begin
            state_q <= S_FETCH;
          end else begin
            paceCnt_q <= paceCnt_q - 8'd1;
          end
        end
        S_WAITSTEP: begin
          if (bus.step) begin
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status and handshake outputs come straight from registers.
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instrValid_q;
  assign bus.pc          = pc_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Drives the sequencer through paced runs, back-pressure, single stepping,
// end-of-memory halt, stop and asynchronous reset. A reference process
// tracks, from the externally visible rules only, which address must be on
// pc, which word must be on instr, and on which cycle the next valid must
// appear; directed sections add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam int DEPTH = 100;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int PACE  = 4;

  localparam logic [DW-1:0] WordPlain = 32'h00100100;
  localparam logic [DW-1:0] WordHalt  = 32'h001001F0;

  logic clk;
  logic rst_n;

  instr_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  instr_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PACE  (PACE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int expPc = 0;
  int xferCount = 0;
  logic [DW-1:0] modelMem [DEPTH];

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if the clock loop is left behind.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic stp,
                               input logic md, input logic rdy);
    bus.start       = st;
    bus.stop        = sp;
    bus.step        = stp;
    bus.mode        = md;
    bus.instr_ready = rdy;
  endtask

  task automatic writeWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic waitValid(input string name, input int maxCyc);
    int n = 0;
    while (!bus.instr_valid && n < maxCyc) begin
      tick();
      n++;
    end
    checkOutput(name, bus.instr_valid, 1);
  endtask

  task automatic waitDone(input string name, input int maxCyc);
    int n = 0;
    while (!bus.done && n < maxCyc) begin
      tick();
      n++;
    end
    checkOutput(name, bus.done, 1);
  endtask

  task automatic pulseStep();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
  endtask

  // Reference process, sampling on the falling edge. It knows only the
  // observable rules: each transfer moves to the next address unless the
  // word is a halt marker or the last address; a new word appears three
  // sampled cycles after an accepted start or step, and PACE+3 cycles after
  // a paced transfer; stop cancels anything pending.
  initial begin : compareProc
    int cyc = 0;
    int expRise = -1;
    bit waitStep = 1'b0;
    bit haltNext = 1'b0;
    bit stopNext = 1'b0;
    logic prevValid = 1'b0;
    logic rise;
    logic isHalt;
    logic [DW-1:0] word;
    foreach (modelMem[i]) modelMem[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        checkOutput("resetValid", bus.instr_valid, 0);
        checkOutput("resetPc", bus.pc, 0);
        checkOutput("resetBusy", bus.busy, 0);
        checkOutput("resetDone", bus.done, 0);
        expPc     = 0;
        expRise   = -1;
        waitStep  = 1'b0;
        haltNext  = 1'b0;
        stopNext  = 1'b0;
        prevValid = 1'b0;
      end else begin
        rise = bus.instr_valid && !prevValid;
        checkOutput("pc", bus.pc, expPc);
        if (bus.instr_valid) checkOutput("instr", bus.instr, modelMem[expPc]);
        if (rise) begin
          checkOutput("riseCycle", cyc, expRise);
          expRise = -1;
        end else if (expRise >= 0 && cyc >= expRise) begin
          checkOutput("riseMissing", rise, 1);
          expRise = -1;
        end
        if (haltNext) begin
          checkOutput("haltDone", bus.done, 1);
          checkOutput("haltBusy", bus.busy, 0);
          haltNext = 1'b0;
        end
        if (stopNext) begin
          checkOutput("stopValid", bus.instr_valid, 0);
          checkOutput("stopBusy", bus.busy, 0);
          stopNext = 1'b0;
        end
        if (waitStep && bus.step) begin
          expRise  = cyc + 3;
          waitStep = 1'b0;
        end
        if (bus.instr_valid && bus.instr_ready) begin
          xferCount++;
          word   = modelMem[expPc];
          isHalt = (word[7:4] == 4'hF) || (expPc == DEPTH - 1);
          if (isHalt) begin
            haltNext = !bus.stop;
          end else begin
            expPc++;
            if (bus.mode) waitStep = 1'b1;
            else          expRise  = cyc + PACE + 3;
          end
        end
        if (bus.start && !bus.stop && !bus.busy) begin
          expPc   = 0;
          expRise = cyc + 3;
        end
        if (bus.stop) begin
          expRise  = -1;
          waitStep = 1'b0;
          haltNext = 1'b0;
          if (bus.busy) stopNext = 1'b1;
        end
        if (bus.wr_en && (bus.wr_addr < DEPTH)) modelMem[bus.wr_addr] = bus.wr_data;
        prevValid = bus.instr_valid;
      end
    end
  end

  // Directed sequence with literal expectations.
  initial begin : mainProc
    int t;
    int riseCnt;
    int secondRise;
    int xferBase;
    logic prev;

    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rstValid", bus.instr_valid, 0);
    checkOutput("rstPc", bus.pc, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstInstr", bus.instr, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] paced run of a four-word program");
    writeWord(7'd0, WordPlain);
    writeWord(7'd1, WordPlain);
    writeWord(7'd2, WordPlain);
    writeWord(7'd3, WordHalt);
    xferBase = xferCount;
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    checkOutput("latencyEarly", bus.instr_valid, 0);
    tick();
    checkOutput("latencyValid", bus.instr_valid, 1);
    checkOutput("firstInstr", bus.instr, WordPlain);
    checkOutput("firstPc", bus.pc, 0);
    riseCnt    = 1;
    secondRise = 0;
    prev       = 1'b1;
    t          = 2;
    while (!bus.done && t < 60) begin
      tick();
      t++;
      if (bus.instr_valid && !prev) begin
        riseCnt++;
        if (riseCnt == 2) secondRise = t;
      end
      prev = bus.instr_valid;
    end
    checkOutput("riseCount", riseCnt, 4);
    checkOutput("riseGap", secondRise - 2, 7);
    checkOutput("run1Done", bus.done, 1);
    checkOutput("run1Busy", bus.busy, 0);
    checkOutput("run1Pc", bus.pc, 3);
    checkOutput("run1Xfers", xferCount - xferBase, 4);

    $display("[TB] back-pressure on the first word");
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    waitValid("bpValid", 10);
    repeat (10) tick();
    checkOutput("bpInstr", bus.instr, WordPlain);
    checkOutput("bpHeld", bus.instr_valid, 1);
    checkOutput("bpPc", bus.pc, 0);
    checkOutput("bpDoneCleared", bus.done, 0);
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    checkOutput("bpXferValid", bus.instr_valid, 0);
    checkOutput("bpXferPc", bus.pc, 1);
    waitDone("bpDone", 100);

    $display("[TB] single-step with step pulses");
    applyStimulus(1, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 1);
    waitValid("stepFirst", 10);
    repeat (6) tick();
    checkOutput("stepIdleValid", bus.instr_valid, 0);
    checkOutput("stepIdlePc", bus.pc, 1);
    pulseStep();
    tick();
    tick();
    checkOutput("stepValid", bus.instr_valid, 1);
    checkOutput("stepPc", bus.pc, 1);
    tick();
    repeat (2) tick();
    pulseStep();
    waitValid("step3", 5);
    tick();
    repeat (5) tick();
    pulseStep();
    waitDone("stepDone", 20);
    checkOutput("stepHaltPc", bus.pc, 3);

    $display("[TB] end-of-memory halt");
    for (int i = 0; i < DEPTH; i++) begin
      writeWord(AW'(i), 32'h1000_0001 | (32'(i) << 8));
    end
    xferBase = xferCount;
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    waitDone("endDone", 1000);
    checkOutput("endPc", bus.pc, 99);
    checkOutput("endBusy", bus.busy, 0);
    checkOutput("endXfers", xferCount - xferBase, 100);
    repeat (10) tick();
    checkOutput("endNoRefetch", bus.instr_valid, 0);
    checkOutput("endPcHeld", bus.pc, 99);

    $display("[TB] step held high");
    applyStimulus(1, 0, 1, 1, 1);
    tick();
    applyStimulus(0, 0, 1, 1, 1);
    riseCnt = 0;
    prev    = bus.instr_valid;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.instr_valid && !prev) riseCnt++;
      prev = bus.instr_valid;
    end
    checkOutput("heldRises", riseCnt, 5);
    applyStimulus(0, 1, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("heldStopBusy", bus.busy, 0);
    checkOutput("heldStopPc", bus.pc, 5);
    checkOutput("heldDone", bus.done, 0);

    $display("[TB] stop during pacing");
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    t = 0;
    while (!(bus.pc == 7'd5 && !bus.instr_valid) && t < 100) begin
      tick();
      t++;
    end
    checkOutput("paceReach", bus.pc, 5);
    applyStimulus(0, 1, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("paceStopValid", bus.instr_valid, 0);
    checkOutput("paceStopPc", bus.pc, 5);
    checkOutput("paceStopBusy", bus.busy, 0);
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    waitValid("restartValid", 10);
    checkOutput("restartInstr", bus.instr, 32'h1000_0001);
    checkOutput("restartPc", bus.pc, 0);

    $display("[TB] asynchronous reset while presenting");
    t = 0;
    while (!(bus.pc == 7'd2 && bus.instr_valid) && t < 100) begin
      tick();
      t++;
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("presentPc", bus.pc, 2);
    writeWord(7'd7, 32'hDEADBEEF);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncValid", bus.instr_valid, 0);
    checkOutput("asyncPc", bus.pc, 0);
    checkOutput("asyncDone", bus.done, 0);
    checkOutput("asyncBusy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    t = 0;
    while (!(bus.pc == 7'd7 && bus.instr_valid) && t < 100) begin
      tick();
      t++;
    end
    checkOutput("keptWord", bus.instr, 32'hDEADBEEF);
    applyStimulus(0, 1, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
